// File: rtl/nfc_ecc_rf_buf_pkg.sv
// nfc_pkg: shared widths, types and lane-merge helper for the NFC ECC register-file buffer
package nfc_pkg;
  localparam int DAT_WID  = 16;
  localparam int RF_AWID  = 4;
  localparam int BYTE_WID = DAT_WID / 2;
  localparam int RF_DEPTH = 1 << RF_AWID;
  typedef logic [DAT_WID-1:0]  word_t;
  typedef logic [RF_AWID-1:0]  addr_t;
  typedef logic [1:0]          lane_t;
  function automatic word_t lane_merge(word_t old_w, word_t new_w, lane_t we);
    return {we[1] ? new_w[DAT_WID-1:BYTE_WID] : old_w[DAT_WID-1:BYTE_WID],
            we[0] ? new_w[BYTE_WID-1:0]       : old_w[BYTE_WID-1:0]};
  endfunction
endpackage

// File: rtl/nfc_ecc_rf_buf_if.sv
// nfc_ecc_rf_buf_if: register-file access and strobe request signals between the ECC engine and the buffer
interface nfc_ecc_rf_buf_if;
  import nfc_pkg::*;
  lane_t write;
  addr_t addr_wr;
  word_t data_in;
  logic  read;
  addr_t addr_rd;
  word_t data_out;
  logic  pulse_in;
  logic  pulse_out;
  modport master (output write, addr_wr, data_in, read, addr_rd, pulse_in, input data_out, pulse_out);
  modport slave  (input write, addr_wr, data_in, read, addr_rd, pulse_in, output data_out, pulse_out);
endinterface

// File: rtl/nfc_ecc_rf_buf_pulse.sv
// nfc_pulse_edge: turns a request level or pulse of any length into a single-cycle registered strobe
module nfc_pulse_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic pulse_out
);
  logic history;
  always_ff @(posedge clk)
    if (rst) begin
      history   <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      history   <= pulse_in;
      pulse_out <= pulse_in & ~history;
    end
endmodule

// File: rtl/nfc_ecc_rf_buf.sv
// nfc_ecc_rf_buf: 16x16 byte-lane register file with registered read plus request strobe conditioner
module nfc_ecc_rf_buf
  import nfc_pkg::*;
(
  input logic            clk,
  input logic            rst,
  nfc_ecc_rf_buf_if.slave bus
);
  word_t mem [RF_DEPTH];
  // read samples the pre-write contents, so a same-address read/write returns the old word
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
      bus.data_out <= '0;
    end else begin
      if (bus.read) bus.data_out <= mem[bus.addr_rd];
      if (|bus.write) mem[bus.addr_wr] <= lane_merge(mem[bus.addr_wr], bus.data_in, bus.write);
    end
  nfc_pulse_edge u_pulse (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (bus.pulse_in),
    .pulse_out(bus.pulse_out)
  );
endmodule

// File: tb/tb_nfc_ecc_rf_buf.sv
// tb_nfc_ecc_rf_buf: directed stimulus with queued expectations checked by an independent monitor
module tb_nfc_ecc_rf_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string       nm;
    logic [15:0] d;
    logic        p;
  } exp_t;
  exp_t q[$];
  nfc_ecc_rf_buf_if bus();
  nfc_ecc_rf_buf dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (bus.data_out !== e.d || bus.pulse_out !== e.p) begin
        fails++;
        $display("FAIL %s: data_out=%h pulse_out=%b, want data_out=%h pulse_out=%b",
                 e.nm, bus.data_out, bus.pulse_out, e.d, e.p);
      end
    end
  end
  task automatic step(input logic r, input logic [1:0] w, input logic [3:0] aw, input logic [15:0] di,
                      input logic rd, input logic [3:0] ar, input logic pi,
                      input logic [15:0] ed, input logic ep, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; bus.write = w; bus.addr_wr = aw; bus.data_in = di;
    bus.read = rd; bus.addr_rd = ar; bus.pulse_in = pi;
    @(posedge clk);
    e.nm = nm; e.d = ed; e.p = ep;
    q.push_back(e);
  endtask
  initial begin
    int wait_cnt;
    bus.write = 2'b00; bus.addr_wr = '0; bus.data_in = '0;
    bus.read = 1'b0; bus.addr_rd = '0; bus.pulse_in = 1'b0;
    step(1, 2'b00, 0, 16'h0, 0, 0, 0, 16'h0000, 0, "reset0");
    step(1, 2'b11, 2, 16'hFFFF, 1, 2, 0, 16'h0000, 0, "reset_ignores_wr");
    for (int a = 0; a < 16; a++)
      step(0, 2'b00, 0, 16'h0, 1, 4'(a), 0, 16'h0000, 0, $sformatf("rst_rd_%0d", a));
    step(0, 2'b01, 3, 16'hAA55, 0, 0, 0, 16'h0000, 0, "lo_wr");
    step(0, 2'b10, 3, 16'h1234, 0, 0, 0, 16'h0000, 0, "hi_wr");
    step(0, 2'b00, 0, 16'h0, 1, 3, 0, 16'h1255, 0, "lane_rd");
    step(0, 2'b10, 9, 16'hABCD, 0, 0, 0, 16'h1255, 0, "hi_only_wr");
    step(0, 2'b00, 9, 16'hFFFF, 1, 9, 0, 16'hAB00, 0, "hi_only_rd");
    step(0, 2'b11, 15, 16'hBEEF, 0, 0, 0, 16'hAB00, 0, "full_wr");
    step(0, 2'b00, 0, 16'h0, 1, 15, 0, 16'hBEEF, 0, "full_rd");
    step(0, 2'b00, 0, 16'h0, 0, 3, 0, 16'hBEEF, 0, "hold_a");
    step(0, 2'b00, 0, 16'h0, 0, 9, 0, 16'hBEEF, 0, "hold_b");
    step(0, 2'b11, 5, 16'h0001, 0, 0, 0, 16'hBEEF, 0, "rbw_setup");
    step(0, 2'b11, 5, 16'h00FF, 1, 5, 0, 16'h0001, 0, "rbw_old");
    step(0, 2'b00, 0, 16'h0, 1, 5, 0, 16'h00FF, 0, "rbw_new");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 1, "long_p1");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 0, "long_p2");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 0, "long_p3");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 0, "long_p4");
    step(0, 2'b00, 0, 16'h0, 0, 0, 0, 16'h00FF, 0, "long_idle");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 1, "b2b_1");
    step(0, 2'b00, 0, 16'h0, 0, 0, 0, 16'h00FF, 0, "b2b_0");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h00FF, 1, "b2b_2");
    step(0, 2'b00, 0, 16'h0, 0, 0, 0, 16'h00FF, 0, "b2b_idle");
    step(0, 2'b11, 7, 16'hCAFE, 0, 0, 0, 16'h00FF, 0, "mid_wr");
    step(1, 2'b11, 7, 16'h1111, 1, 7, 1, 16'h0000, 0, "mid_rst");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h0000, 1, "post_rst_strobe");
    step(0, 2'b00, 0, 16'h0, 0, 0, 1, 16'h0000, 0, "post_rst_single");
    step(0, 2'b00, 0, 16'h0, 1, 7, 0, 16'h0000, 0, "post_rst_rd7");
    step(0, 2'b00, 0, 16'h0, 1, 15, 0, 16'h0000, 0, "post_rst_rd15");
    step(0, 2'b00, 0, 16'h0, 1, 3, 0, 16'h0000, 0, "post_rst_rd3");
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nfc_ecc_rf_buf.md
Name: nfc_ecc_rf_buf

Overview:
- Single-clock storage and strobe block for the NFC ECC correction path.
- Contains a 16-entry x 16-bit register file with independent byte-lane write enables and a registered read port.
- Contains a pulse conditioner that turns any-length request level/pulse into a single-cycle strobe.
- Buffers ECC encode bytes / decode error addresses between the ECC engine and the memory-interface reader.

Parameters:
- DAT_WID, 16, register-file word width; must be even, split into two equal byte lanes.
- RF_AWID, 4, register-file address width; depth = 2**RF_AWID = 16.

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- write  in  2  byte-lane write enables: bit0 = low lane, bit1 = high lane.
- addr_wr  in  RF_AWID  write address.
- data_in  in  DAT_WID  write data; low lane [DAT_WID/2-1:0], high lane [DAT_WID-1:DAT_WID/2].
- read  in  1  read enable.
- addr_rd  in  RF_AWID  read address.
- data_out  out  DAT_WID  registered read data.
- pulse_in  in  1  request level or pulse.
- pulse_out  out  1  single-cycle strobe.

Behaviour:
- Reset (rst=1 at a clk edge): every register-file entry becomes 0, data_out=0, pulse_out=0, and the pulse history flop becomes 0.
- Write and read are ignored in any cycle where rst=1.
- Low-lane write: write[0]=1 stores data_in low lane into entry addr_wr low lane. The high lane is untouched.
- High-lane write: write[1]=1 stores data_in high lane into entry addr_wr high lane. The low lane is untouched.
- write=2'b11 writes the full word. write=2'b00 changes nothing.
- Read: read=1 at an edge sets data_out to entry addr_rd (1-cycle latency). read=0 holds data_out.
- Same address read and written in one cycle: read-before-write. data_out gets the pre-write contents; the new data is visible on the next read.
- Addresses use the full RF_AWID range with no bounds check. The block keeps no pointers or wrap logic; the caller owns the addresses.
- Pulse conditioner: a history flop samples pulse_in every edge. pulse_out is registered as pulse_in & ~history.
  - pulse_out rises exactly one cycle after the first high cycle of pulse_in.
  - pulse_out lasts exactly one cycle, whatever the input length.
  - A new strobe needs pulse_in low for at least one cycle, then high again.
- Back-to-back input pulses (1,0,1) produce two strobes separated by one idle cycle.
- Reset mid-operation: storage contents are lost (cleared) and any pending strobe is cancelled. pulse_in held high across reset release produces one strobe, one cycle after the first post-reset edge.
- The register-file and pulse-conditioner paths are fully independent; there is no interaction.

Decomposition:
- Shared package nfc_pkg: DAT_WID=16, RF_AWID=4, and derived constants BYTE_WID=DAT_WID/2 and RF_DEPTH=1<<RF_AWID.
- Sub-module nfc_pulse_edge (history flop plus registered edge detect) is instantiated once.
- The register file is written directly in this module.

Test Plan:
- Reset then read: assert rst, then read=1 at addr 0..15 -> data_out=16'h0000 for every address; pulse_out=0 throughout.
- Lane writes: write=2'b01 addr 3 data 16'hAA55, then write=2'b10 addr 3 data 16'h1234, then read addr 3 -> data_out=16'h1255 one cycle after read.
- Full word and hold: write=2'b11 addr 15 data 16'hBEEF, read addr 15 -> 16'hBEEF. Then read=0 with addr_rd changed -> data_out stays 16'hBEEF.
- Read-before-write: addr 5 holds 16'h0001; same cycle write=2'b11 16'h00FF and read addr 5 -> data_out=16'h0001. Next read -> 16'h00FF.
- Pulse shaping:
  - pulse_in high 4 cycles -> one pulse_out, 1 cycle wide, asserted 1 cycle after pulse_in rise.
  - Pattern 1,0,1 -> two strobes 2 cycles apart.
- Reset mid-op: write data, pulse_in rising, assert rst the same cycle -> pulse_out stays 0 and memory reads 0 after reset. pulse_in still high at reset release -> one strobe, one cycle after the first post-reset edge.
